// File: rtl/ascii_pkg.sv
// Shared console definitions: serializer state encoding and ASCII constants.
package ascii_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [7:0] ASCII_NUL = 8'h00;
endpackage

// File: rtl/ascii_shift_reg.sv
// Byte-wide message shift register.
// Exposes the leading char and a flag that says every later byte is NUL.
module ascii_shift_reg
    import ascii_pkg::*;
#(
    parameter int MSG_BYTES = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_i,
    input  logic                   shift_i,
    input  logic [8*MSG_BYTES-1:0] data_i,
    output logic [7:0]             top_o,
    output logic                   rest_zero_o
);
    logic [8*MSG_BYTES-1:0] sh_q, sh_d;

    // Shifting pulls NULs in at the bottom, so rest_zero stays meaningful.
    always_comb begin
        sh_d = sh_q;
        if (load_i)
            sh_d = data_i;
        else if (shift_i)
            sh_d = {sh_q[8*MSG_BYTES-9:0], ASCII_NUL};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sh_q <= '0;
        else
            sh_q <= sh_d;
    end

    assign top_o       = sh_q[8*MSG_BYTES-1 -: 8];
    assign rest_zero_o = (sh_q[8*MSG_BYTES-9:0] == '0);
endmodule

// File: rtl/ascii_serializer.sv
// Streams a fixed-length ASCII message onto a valid/ready char sink,
// optionally dropping NULs and ending once only NULs remain.
module ascii_serializer
    import ascii_pkg::*;
#(
    parameter int MSG_BYTES = 24,
    parameter bit SKIP_NUL  = 1'b1,
    localparam int CNT_W    = $clog2(MSG_BYTES),
    localparam int SC_W     = $clog2(MSG_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [8*MSG_BYTES-1:0] msg,
    output logic                   char_valid,
    output logic [7:0]             char_data,
    output logic                   char_last,
    input  logic                   char_ready,
    output logic                   busy,
    output logic                   done,
    output logic [SC_W-1:0]        sent_count
);
    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SC_W-1:0] sent_q, sent_d;
    logic [7:0]      top;
    logic            rest_zero;
    logic            in_send, skip, xfer, advance, fin, load, shift;

    assign in_send = (state_q == ST_SEND);
    assign skip    = in_send && SKIP_NUL && (top == ASCII_NUL);
    assign xfer    = in_send && !skip && char_ready;
    assign advance = skip || xfer;
    assign fin     = (cnt_q == '0) || (SKIP_NUL && rest_zero);
    assign load    = (state_q == ST_IDLE) && start && !abort;
    assign shift   = advance && !abort;

    ascii_shift_reg #(
        .MSG_BYTES(MSG_BYTES)
    ) u_sh (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .shift_i    (shift),
        .data_i     (msg),
        .top_o      (top),
        .rest_zero_o(rest_zero)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sent_d  = sent_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEND;
                    cnt_d   = CNT_W'(MSG_BYTES - 1);
                    sent_d  = '0;
                end
            end
            ST_SEND: begin
                if (advance) begin
                    if (cnt_q != '0)
                        cnt_d = cnt_q - CNT_W'(1);
                    if (xfer)
                        sent_d = sent_q + SC_W'(1);
                    if (fin)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over everything; the count keeps what was already sent.
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = cnt_q;
            sent_d  = sent_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
        end
    end

    assign char_valid = in_send && !skip;
    assign char_data  = in_send ? top : '0;
    assign char_last  = in_send && fin;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign sent_count = sent_q;
endmodule

// File: tb/tb_ascii_serializer.sv
// Randomized and directed bench for ascii_serializer, both NUL modes.
module tb_ascii_serializer;
    localparam int N = 24;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [8*N-1:0] msg = '0;
    logic [1:0]     st = '0;
    logic [1:0]     ab = '0;
    logic [1:0]     rdy = '0;
    logic [1:0]     cv, cl, bsy, dn;
    logic [7:0]     cd [2];
    logic [4:0]     sc [2];

    int ncomp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    ascii_serializer #(.MSG_BYTES(N), .SKIP_NUL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]), .msg(msg),
        .char_valid(cv[0]), .char_data(cd[0]), .char_last(cl[0]),
        .char_ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .sent_count(sc[0])
    );

    ascii_serializer #(.MSG_BYTES(N), .SKIP_NUL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]), .msg(msg),
        .char_valid(cv[1]), .char_data(cd[1]), .char_last(cl[1]),
        .char_ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .sent_count(sc[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*N-1:0] rand_msg();
        logic [8*N-1:0] m;
        for (int k = 0; k < N; k++)
            m[8*(N-k)-1 -: 8] = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(32, 126));
        return m;
    endfunction

    task automatic run(input int s, input logic [8*N-1:0] m, input int pct, input int abort_after);
        logic [7:0] q[$];
        logic [7:0] c, prev;
        int last_pos, idx, exp_done;
        bit fin, stalled;
        last_pos = 0;
        for (int k = 0; k < N; k++) begin
            c = m[8*(N-k)-1 -: 8];
            if (s == 0 || c != 8'h00) begin
                q.push_back(c);
                last_pos = k;
            end
        end
        exp_done = last_pos + 2;
        idx = 0;
        fin = 0;
        stalled = 0;
        prev = '0;
        @(negedge clk);
        msg = m;
        st[s] = 1'b1;
        rdy[s] = (pct >= 100);
        for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
            @(negedge clk);
            st[s] = (cyc == 3);
            if (cyc == 3)
                msg = rand_msg();
            if (ab[s]) begin
                ab[s] = 1'b0;
                chk("abort_valid", 32'(cv[s]), 0);
                chk("abort_busy", 32'(bsy[s]), 0);
                chk("abort_done", 32'(dn[s]), 0);
                chk("abort_sent", 32'(sc[s]), 32'(abort_after));
                fin = 1;
            end else if (dn[s]) begin
                if (pct >= 100)
                    chk("done_cycle", 32'(cyc), 32'(exp_done));
                chk("done_count", 32'(idx), 32'(q.size()));
                chk("done_sent", 32'(sc[s]), 32'(q.size()));
                chk("done_busy", 32'(bsy[s]), 1);
                chk("done_valid", 32'(cv[s]), 0);
                fin = 1;
            end else begin
                chk("send_busy", 32'(bsy[s]), 1);
                if (cv[s]) begin
                    if (stalled)
                        chk("stall_data", 32'(cd[s]), 32'(prev));
                    if (idx >= q.size())
                        chk("extra_char", 32'(idx), 32'(q.size() - 1));
                    else begin
                        chk("char_data", 32'(cd[s]), 32'(q[idx]));
                        chk("char_last", 32'(cl[s]), 32'(idx == q.size() - 1));
                    end
                end
                if (abort_after >= 0 && idx == abort_after) begin
                    ab[s] = 1'b1;
                    rdy[s] = 1'b0;
                end else begin
                    rdy[s] = ($urandom_range(99) < pct);
                    if (cv[s]) begin
                        stalled = !rdy[s];
                        prev = cd[s];
                        if (rdy[s])
                            idx++;
                    end
                end
            end
        end
        st[s] = 1'b0;
        rdy[s] = 1'b0;
        if (!fin)
            chk("timeout", 0, 1);
        @(negedge clk);
        chk("idle_busy", 32'(bsy[s]), 0);
        chk("idle_done", 32'(dn[s]), 0);
        chk("idle_valid", 32'(cv[s]), 0);
    endtask

    initial begin
        logic [8*N-1:0] hello, a0b;
        hello = {"HELLO, WORLD!", 88'h0};
        a0b = {"A", 8'h00, "B", 168'h0};
        #12;
        chk("rst_valid", 32'({cv, cl}), 0);
        chk("rst_busy", 32'({bsy, dn}), 0);
        chk("rst_data", 32'({cd[0], cd[1]}), 0);
        chk("rst_sent", 32'({sc[0], sc[1]}), 0);
        rst_n = 1'b1;
        run(1, hello, 100, -1);
        run(0, hello, 100, -1);
        run(1, a0b, 100, -1);
        for (int i = 0; i < 3; i++) begin
            run(1, rand_msg(), 30, -1);
            run(0, rand_msg(), 30, -1);
        end
        run(1, '0, 100, -1);
        run(1, hello, 100, 5);
        @(negedge clk);
        msg = hello;
        st[1] = 1'b1;
        rdy[1] = 1'b1;
        @(negedge clk);
        st[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_valid", 32'(cv[1]), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(cv[1]), 0);
        chk("mid_rst_busy", 32'(bsy[1]), 0);
        chk("mid_rst_data", 32'(cd[1]), 0);
        chk("mid_rst_sent", 32'(sc[1]), 0);
        chk("mid_rst_last", 32'({cl[1], dn[1]}), 0);
        rdy[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
